muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide sequencer in the EX stage. It accepts mult, multu, div and divu from the decoded control bus (the instructions with hilo_mode = 11). It runs a single-cycle-issue multiplier or a 32-iteration restoring divider, stalls the pipeline while busy, and delivers HI/LO write data with a one-cycle write strobe. It contains the divider datapath and the FSM that sequences it. Pipeline flush from exception or eret cancels any operation in flight.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported; the iteration counter is sized log2(WIDTH)+1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
op_valid  in  1  EX holds a mul/div instruction; held stable while busy=1
op_code  in  2  00 mult, 01 multu, 10 div, 11 divu
src_a  in  32  rs value (multiplicand/dividend), sampled on accept only
src_b  in  32  rt value (multiplier/divisor), sampled on accept only
flush  in  1  cancel current operation (exception/eret)
busy  out  1  stall request to IF/ID/EX
res_valid  out  1  one-cycle HI and LO write strobe
res_hi  out  32  HI write data (product high / remainder)
res_lo  out  32  LO write data (product low / quotient)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, busy=0, res_valid=0, res_hi=0, res_lo=0, counter=0, internal registers 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: in IDLE, op_valid=1 and flush=0. Latch operands and op_code. Go to MUL (op_code[1]=0) or DIV (op_code[1]=1).
- busy (combinational) = ~flush & ((IDLE & op_valid) | MUL | DIV | FIX). busy=0 in DONE.
- MUL: one cycle. Signed (mult) or unsigned (multu) 32x32->64 product registered into res_hi/res_lo. Next state DONE.
- DIV: on accept, latch |a| and |b| (magnitudes for div, raw values for divu), signs sa/sb, counter=31, remainder=0.
  - Each DIV cycle: one restoring step, shifting in the dividend MSB first.
  - Trial = {rem[30:0], next bit} - divisor. If non-negative, keep it and set the quotient bit to 1; otherwise the quotient bit is 0.
  - Counter decrements each cycle. 32 DIV cycles, then FIX.
- FIX: one cycle, signed only. Quotient negated if sa^sb. Remainder negated if sa. Results written to res_lo/res_hi. Unsigned ops pass through unchanged. Next state DONE.
- DONE: res_valid=1 for exactly this cycle and busy=0, so the pipeline advances. Next state IDLE unconditionally. op_valid is ignored in DONE because it still belongs to the completing instruction.
- Latency from the accept cycle (cycle 0):
  - mult/multu: res_valid in cycle 2, busy high cycles 0-1.
  - div/divu: res_valid in cycle 34, busy high cycles 0-33.
- Back-to-back: a new op in EX the cycle after DONE is accepted from IDLE normally.
- Divide by zero (no exception raised): deterministic algorithm result.
  - divu: lo=FFFFFFFF, hi=src_a.
  - div: hi=src_a; lo=00000001 if src_a<0, else FFFFFFFF.
- Overflow div 80000000/FFFFFFFF: lo=80000000, hi=00000000 (magnitude arithmetic in 32-bit unsigned).
- res_hi/res_lo hold their last completed value. They update only on MUL exit or FIX exit, and are observed only while res_valid=1.
- flush: in any state, the next state is IDLE and busy drops in the same cycle. res_valid is never asserted for a cancelled op. Completion-path writes of res_hi/res_lo are suppressed that cycle. flush in IDLE blocks accept. flush in DONE does not suppress res_valid (instruction already committed to HI/LO).
- Reset mid-operation: immediate return to reset values. No res_valid afterwards.

Test Plan:
- mult src_a=FFFFFFFD(-3), src_b=00000005 -> busy cycles 0-1; cycle 2 res_valid=1, hi=FFFFFFFF, lo=FFFFFFF1; cycle 3 res_valid=0.
- multu FFFFFFFF x FFFFFFFF -> cycle 2 hi=FFFFFFFE, lo=00000001. An immediately following mult 2x3 gives res_valid at its own cycle 2 with lo=6, hi=0.
- divu 100/7 -> res_valid only at cycle 34, lo=0000000E, hi=00000002. div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- div by zero: div src_a=FFFFFFF0, src_b=0 -> lo=00000001, hi=FFFFFFF0. divu 5/0 -> lo=FFFFFFFF, hi=00000005. div 80000000/FFFFFFFF -> lo=80000000, hi=0.
- Flush during div, cycle 10 -> busy=0 that cycle; no res_valid ever; res_hi/res_lo keep prior values. New divu issued next cycle completes at its cycle 34 with correct data.
- rst pulsed asynchronously mid-DIV (between edges) -> busy, res_valid, res_hi, res_lo all 0 immediately. After release, op_valid low -> busy stays 0. Flush asserted in DONE -> res_valid still 1.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the EX-stage control and the mul/div sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             op_valid;
   logic [1:0]       op_code;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             busy;
   logic             res_valid;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   modport master (
      output op_valid, op_code, src_a, src_b, flush,
      input  busy, res_valid, res_hi, res_lo
   );

   modport slave (
      input  op_valid, op_code, src_a, src_b, flush,
      output busy, res_valid, res_hi, res_lo
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: single-cycle multiply, 32-step restoring
// divide with sign fix-up, pipeline stall while busy and a one-cycle HI/LO strobe.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;

   logic             accept;
   logic             op_signed;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic [WIDTH:0]   trial;

   assign accept    = (state_q == S_IDLE) & bus.op_valid & ~bus.flush;
   assign op_signed = ~bus.op_code[0];

   assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
   assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
   assign prod  = ext_a * ext_b;

   // rem stays below 2^(WIDTH-1) until the last shift, so its MSB is never lost here.
   assign trial = {1'b0, rem_q[WIDTH-2:0], a_q[WIDTH-1]} - {1'b0, b_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      sa_d    = sa_q;
      sb_d    = sb_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sgn_d = op_signed;
               if (bus.op_code[1]) begin
                  sa_d    = op_signed & bus.src_a[WIDTH-1];
                  sb_d    = op_signed & bus.src_b[WIDTH-1];
                  a_d     = (op_signed & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
                  b_d     = (op_signed & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = S_DIV;
               end else begin
                  a_d     = bus.src_a;
                  b_d     = bus.src_b;
                  state_d = S_MUL;
               end
            end
         end
         S_MUL: begin
            {hi_d, lo_d} = prod;
            state_d      = S_DONE;
         end
         S_DIV: begin
            // a_q doubles as dividend shifter (out at MSB) and quotient (in at LSB).
            a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], a_q[WIDTH-1]} : trial[WIDTH-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_FIX;
         end
         S_FIX: begin
            lo_d    = (sa_q ^ sb_q) ? -a_q : a_q;
            hi_d    = sa_q ? -rem_q : rem_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
      end
   end

   // No stall is requested while reset is held, even if EX still shows an op.
   assign bus.busy = ~rst & ~bus.flush &
                     (((state_q == S_IDLE) & bus.op_valid) | (state_q == S_MUL) |
                      (state_q == S_DIV) | (state_q == S_FIX));
   assign bus.res_valid = (state_q == S_DONE);
   assign bus.res_hi    = hi_q;
   assign bus.res_lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus random bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   nchk = 0;
   int   nerr = 0;
   logic [63:0] last;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sp;
      longint unsigned up;
      int          sa, sb, q, r;
      case (c)
         2'b00: begin
            sa = a; sb = b;
            sp = longint'(sa) * longint'(sb);
            return sp;
         end
         2'b01: begin
            up = {32'd0, a};
            up = up * {32'd0, b};
            return up;
         end
         2'b10: begin
            if (b == 0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Called just after a negedge with the sequencer idle; returns one cycle after DONE.
   task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit flush_done);
      logic [63:0] e;
      int lat;
      e   = model(c, a, b);
      lat = c[1] ? 34 : 2;
      bus.op_valid = 1'b1;
      bus.op_code  = c;
      bus.src_a    = a;
      bus.src_b    = b;
      #1 chk("busy_accept", 64'(bus.busy), 64'd1);
      for (int k = 1; k < lat; k++) begin
         @(negedge clk);
         chk("busy_run", 64'(bus.busy), 64'd1);
         chk("rv_early", 64'(bus.res_valid), 64'd0);
      end
      @(negedge clk);
      if (flush_done) bus.flush = 1'b1;
      #1;
      chk("rv_done", 64'(bus.res_valid), 64'd1);
      chk("busy_done", 64'(bus.busy), 64'd0);
      chk("res_hi", 64'(bus.res_hi), 64'(e[63:32]));
      chk("res_lo", 64'(bus.res_lo), 64'(e[31:0]));
      last = e;
      bus.op_valid = 1'b0;
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("rv_after", 64'(bus.res_valid), 64'd0);
      chk("busy_after", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      logic [1:0]  c;
      logic [31:0] a, b;
      rst          = 1'b1;
      bus.op_valid = 1'b0;
      bus.op_code  = 2'b00;
      bus.src_a    = '0;
      bus.src_b    = '0;
      bus.flush    = 1'b0;
      last         = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_rv", 64'(bus.res_valid), 64'd0);
      chk("rst_hi", 64'(bus.res_hi), 64'd0);
      chk("rst_lo", 64'(bus.res_lo), 64'd0);
      @(negedge clk);

      // Directed cases, mul followed immediately by another mul.
      run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 1'b0);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(2'b00, 32'd2, 32'd3, 1'b0);
      run_op(2'b11, 32'd100, 32'd7, 1'b0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
      run_op(2'b10, 32'hFFFFFFF0, 32'd0, 1'b0);
      run_op(2'b11, 32'd5, 32'd0, 1'b0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

      // Flush in DIV cycle 10: no strobe, results held, new divu right after.
      bus.op_valid = 1'b1;
      bus.op_code  = 2'b11;
      bus.src_a    = 32'd1000;
      bus.src_b    = 32'd3;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk("rv_pre_flush", 64'(bus.res_valid), 64'd0);
      end
      bus.flush = 1'b1;
      #1 chk("flush_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      #1;
      chk("flush_rv", 64'(bus.res_valid), 64'd0);
      chk("flush_hi_hold", 64'(bus.res_hi), 64'(last[63:32]));
      chk("flush_lo_hold", 64'(bus.res_lo), 64'(last[31:0]));
      run_op(2'b11, 32'd12345, 32'd97, 1'b0);

      // Flush in DONE must not cancel the strobe.
      run_op(2'b00, 32'd9, 32'hFFFFFFFF, 1'b1);

      // Random operations.
      for (int i = 0; i < 14; i++) begin
         c = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         if (i == 5) begin c = 2'b10; a = 32'h80000000; b = 32'hFFFFFFFF; end
         run_op(c, a, b, 1'b0);
      end

      // Asynchronous reset between edges mid-DIV.
      bus.op_valid = 1'b1;
      bus.op_code  = 2'b10;
      bus.src_a    = 32'h7FFF1234;
      bus.src_b    = 32'd17;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_rv", 64'(bus.res_valid), 64'd0);
      chk("arst_hi", 64'(bus.res_hi), 64'd0);
      chk("arst_lo", 64'(bus.res_lo), 64'd0);
      @(negedge clk);
      bus.op_valid = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         chk("post_rst_busy", 64'(bus.busy), 64'd0);
         chk("post_rst_rv", 64'(bus.res_valid), 64'd0);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
